// File: rtl/mem_read_arbiter_pkg.sv
// Shared constants, state encoding and round-robin helper for the graph-memory read arbiter.
package mem_read_arbiter_pkg;

    localparam int unsigned DEFAULT_NUM_REQ     = 2;
    localparam int unsigned DEFAULT_MADDR_WIDTH = 16;
    localparam int unsigned DEFAULT_MDATA_WIDTH = 32;
    localparam int unsigned DEFAULT_MEM_TIMEOUT = 64;
    localparam int unsigned GRANT_W             = 3;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_ISSUE   = 2'd1,
        ARB_RESPOND = 2'd2
    } arb_state_e;

    // Client index following idx, wrapping at n.
    function automatic logic [GRANT_W-1:0] rr_next(input logic [GRANT_W-1:0] idx,
                                                   input int unsigned n);
        if (32'(idx) + 32'd1 >= n) begin
            return '0;
        end
        return idx + GRANT_W'(1);
    endfunction

endpackage

// File: rtl/mem_read_arbiter_if.sv
// Client request/response and memory read-port signals of the arbiter, with arbiter and far-side views.
interface mem_read_arbiter_if
    import mem_read_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ     = DEFAULT_NUM_REQ,
    parameter int unsigned MADDR_WIDTH = DEFAULT_MADDR_WIDTH,
    parameter int unsigned MDATA_WIDTH = DEFAULT_MDATA_WIDTH
);

    logic [NUM_REQ-1:0]             req_enable;
    logic [NUM_REQ*MADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ-1:0]             req_ready;
    logic [MDATA_WIDTH-1:0]         req_data;
    logic [MADDR_WIDTH-1:0]         mem_addr;
    logic                           mem_read_enable;
    logic [MDATA_WIDTH-1:0]         mem_data;
    logic                           mem_read_ready;
    logic                           busy;
    logic [GRANT_W-1:0]             grant_index;
    logic                           timeout_error;

    // Arbiter side.
    modport master (
        input  req_enable, req_addr, mem_data, mem_read_ready,
        output req_ready, req_data, mem_addr, mem_read_enable,
               busy, grant_index, timeout_error
    );

    // Clients and memory side.
    modport slave (
        output req_enable, req_addr, mem_data, mem_read_ready,
        input  req_ready, req_data, mem_addr, mem_read_enable,
               busy, grant_index, timeout_error
    );

endinterface

// File: rtl/mem_read_arbiter_rr_priority_picker.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping modulo NUM_REQ.
module mem_read_arbiter_rr_priority_picker
    import mem_read_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = DEFAULT_NUM_REQ
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [GRANT_W-1:0] ptr_i,
    output logic               found_c_o,
    output logic [GRANT_W-1:0] index_c_o
);

    // Walk distances from largest to smallest so the nearest requester wins.
    always_comb begin
        found_c_o = 1'b0;
        index_c_o = '0;
        for (int k = int'(NUM_REQ) - 1; k >= 0; k--) begin
            for (int i = 0; i < int'(NUM_REQ); i++) begin
                if (req_i[i] &&
                    (((i >= int'(ptr_i)) ? (i - int'(ptr_i))
                                         : (i + int'(NUM_REQ) - int'(ptr_i))) == k)) begin
                    found_c_o = 1'b1;
                    index_c_o = GRANT_W'(i);
                end
            end
        end
    end

endmodule

// File: rtl/mem_read_arbiter.sv
// Round-robin arbiter sharing the single graph-memory read port; one outstanding read at a time.
module mem_read_arbiter
    import mem_read_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ     = DEFAULT_NUM_REQ,
    parameter int unsigned MADDR_WIDTH = DEFAULT_MADDR_WIDTH,
    parameter int unsigned MDATA_WIDTH = DEFAULT_MDATA_WIDTH,
    parameter int unsigned TIMEOUT     = DEFAULT_MEM_TIMEOUT
) (
    input  logic                  clock,
    input  logic                  reset,
    mem_read_arbiter_if.master    bus
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT);

    arb_state_e             state_q;
    logic [GRANT_W-1:0]     rr_ptr_q;
    logic [GRANT_W-1:0]     grant_q;
    logic [CNT_W-1:0]       wait_cnt_q;
    logic [NUM_REQ-1:0]     req_ready_q;
    logic [MDATA_WIDTH-1:0] req_data_q;
    logic [MADDR_WIDTH-1:0] mem_addr_q;
    logic                   mem_re_q;
    logic                   busy_q;
    logic                   timeout_q;

    logic                   pick_found;
    logic [GRANT_W-1:0]     pick_idx;
    logic [MADDR_WIDTH-1:0] sel_addr;
    logic [NUM_REQ-1:0]     grant_onehot;
    logic [GRANT_W-1:0]     rr_ptr_d;

    mem_read_arbiter_rr_priority_picker #(
        .NUM_REQ   (NUM_REQ)
    ) u_picker (
        .req_i     (bus.req_enable),
        .ptr_i     (rr_ptr_q),
        .found_c_o (pick_found),
        .index_c_o (pick_idx)
    );

    // Address of the picked client and one-hot of the current grant.
    always_comb begin
        sel_addr     = '0;
        grant_onehot = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (pick_idx == GRANT_W'(i)) begin
                sel_addr = bus.req_addr[i*MADDR_WIDTH +: MADDR_WIDTH];
            end
            if (grant_q == GRANT_W'(i)) begin
                grant_onehot[i] = 1'b1;
            end
        end
    end

    assign rr_ptr_d = rr_next(grant_q, NUM_REQ);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= ARB_IDLE;
            rr_ptr_q    <= '0;
            grant_q     <= '0;
            wait_cnt_q  <= '0;
            req_ready_q <= '0;
            req_data_q  <= '0;
            mem_addr_q  <= '0;
            mem_re_q    <= 1'b0;
            busy_q      <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            req_ready_q <= '0;
            case (state_q)
                ARB_IDLE: begin
                    if (pick_found) begin
                        grant_q    <= pick_idx;
                        mem_addr_q <= sel_addr;
                        mem_re_q   <= 1'b1;
                        busy_q     <= 1'b1;
                        wait_cnt_q <= '0;
                        state_q    <= ARB_ISSUE;
                    end
                end
                ARB_ISSUE: begin
                    // A client that withdrew during the read gets no pulse; data still latched.
                    if (bus.mem_read_ready) begin
                        req_data_q  <= bus.mem_data;
                        req_ready_q <= grant_onehot & bus.req_enable;
                        mem_re_q    <= 1'b0;
                        state_q     <= ARB_RESPOND;
                    end else if (wait_cnt_q == CNT_W'(TIMEOUT - 1)) begin
                        timeout_q <= 1'b1;
                        mem_re_q  <= 1'b0;
                        busy_q    <= 1'b0;
                        rr_ptr_q  <= rr_ptr_d;
                        state_q   <= ARB_IDLE;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + CNT_W'(1);
                    end
                end
                ARB_RESPOND: begin
                    rr_ptr_q <= rr_ptr_d;
                    busy_q   <= 1'b0;
                    state_q  <= ARB_IDLE;
                end
                default: begin
                    mem_re_q <= 1'b0;
                    busy_q   <= 1'b0;
                    state_q  <= ARB_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready       = req_ready_q;
    assign bus.req_data        = req_data_q;
    assign bus.mem_addr        = mem_addr_q;
    assign bus.mem_read_enable = mem_re_q;
    assign bus.busy            = busy_q;
    assign bus.grant_index     = grant_q;
    assign bus.timeout_error   = timeout_q;

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Directed self-checking bench for mem_read_arbiter (2 clients, TIMEOUT=8).
module tb_mem_read_arbiter;

    logic clock;
    logic reset;
    int   n_cmp;
    int   n_bad;

    mem_read_arbiter_if #(.NUM_REQ(2), .MADDR_WIDTH(16), .MDATA_WIDTH(32)) bus ();

    mem_read_arbiter #(
        .NUM_REQ     (2),
        .MADDR_WIDTH (16),
        .MDATA_WIDTH (32),
        .TIMEOUT     (8)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.req_enable = '0; bus.req_addr = '0;
        bus.mem_data = '0; bus.mem_read_ready = 1'b0;
        tick(); tick();
        n_cmp++; if (bus.req_ready !== 2'b00) begin n_bad++; $display("FAIL rst_req_ready: got %b want 00", bus.req_ready); end
        n_cmp++; if (bus.req_data !== 32'h0) begin n_bad++; $display("FAIL rst_req_data: got %h want 0", bus.req_data); end
        n_cmp++; if (bus.mem_addr !== 16'h0) begin n_bad++; $display("FAIL rst_mem_addr: got %h want 0", bus.mem_addr); end
        n_cmp++; if (bus.mem_read_enable !== 1'b0) begin n_bad++; $display("FAIL rst_mem_re: got %b want 0", bus.mem_read_enable); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
        n_cmp++; if (bus.grant_index !== 3'd0) begin n_bad++; $display("FAIL rst_grant: got %0d want 0", bus.grant_index); end
        n_cmp++; if (bus.timeout_error !== 1'b0) begin n_bad++; $display("FAIL rst_timeout: got %b want 0", bus.timeout_error); end
        reset = 1'b1;
    endtask

    task automatic test_single();
        bus.req_addr = {16'h0000, 16'h0100};
        bus.req_enable = 2'b01;
        tick();
        n_cmp++; if (bus.mem_read_enable !== 1'b1) begin n_bad++; $display("FAIL single_re: got %b want 1", bus.mem_read_enable); end
        n_cmp++; if (bus.mem_addr !== 16'h0100) begin n_bad++; $display("FAIL single_addr: got %h want 0100", bus.mem_addr); end
        n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL single_busy: got %b want 1", bus.busy); end
        tick();
        n_cmp++; if (bus.req_ready !== 2'b00) begin n_bad++; $display("FAIL single_early_rdy: got %b want 00", bus.req_ready); end
        tick();
        bus.mem_data = 32'hDEADBEEF; bus.mem_read_ready = 1'b1;
        tick();
        n_cmp++; if (bus.req_ready !== 2'b01) begin n_bad++; $display("FAIL single_rdy: got %b want 01", bus.req_ready); end
        n_cmp++; if (bus.req_data !== 32'hDEADBEEF) begin n_bad++; $display("FAIL single_data: got %h want deadbeef", bus.req_data); end
        n_cmp++; if (bus.mem_read_enable !== 1'b0) begin n_bad++; $display("FAIL single_re_drop: got %b want 0", bus.mem_read_enable); end
        bus.mem_read_ready = 1'b0; bus.req_enable = 2'b00;
        tick();
        n_cmp++; if (bus.req_ready !== 2'b00) begin n_bad++; $display("FAIL single_pulse_len: got %b want 00", bus.req_ready); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL single_idle_busy: got %b want 0", bus.busy); end
        n_cmp++; if (bus.req_data !== 32'hDEADBEEF) begin n_bad++; $display("FAIL single_data_hold: got %h want deadbeef", bus.req_data); end
        n_cmp++; if (bus.mem_addr !== 16'h0100) begin n_bad++; $display("FAIL single_addr_hold: got %h want 0100", bus.mem_addr); end
    endtask

    task automatic test_alternate();
        logic [15:0] exp_addr;
        logic [1:0]  exp_rdy;
        logic [31:0] exp_data;
        reset = 1'b0; tick(); reset = 1'b1;
        bus.req_addr = {16'h0020, 16'h0010};
        bus.req_enable = 2'b11;
        for (int k = 0; k < 4; k++) begin
            exp_addr = (k % 2 == 0) ? 16'h0010 : 16'h0020;
            exp_rdy  = (k % 2 == 0) ? 2'b01 : 2'b10;
            exp_data = 32'hA0 + 32'(k);
            tick();
            n_cmp++; if (bus.grant_index !== 3'(k % 2)) begin n_bad++; $display("FAIL alt_grant[%0d]: got %0d want %0d", k, bus.grant_index, k % 2); end
            n_cmp++; if (bus.mem_addr !== exp_addr) begin n_bad++; $display("FAIL alt_addr[%0d]: got %h want %h", k, bus.mem_addr, exp_addr); end
            bus.mem_data = exp_data; bus.mem_read_ready = 1'b1;
            tick();
            n_cmp++; if (bus.req_ready !== exp_rdy) begin n_bad++; $display("FAIL alt_rdy[%0d]: got %b want %b", k, bus.req_ready, exp_rdy); end
            n_cmp++; if (bus.req_data !== exp_data) begin n_bad++; $display("FAIL alt_data[%0d]: got %h want %h", k, bus.req_data, exp_data); end
            bus.mem_read_ready = 1'b0;
            if (k == 3) bus.req_enable = 2'b00;
            tick();
            n_cmp++; if (bus.req_ready !== 2'b00) begin n_bad++; $display("FAIL alt_no_double[%0d]: got %b want 00", k, bus.req_ready); end
            n_cmp++; if (bus.mem_read_enable !== 1'b0) begin n_bad++; $display("FAIL alt_idle_re[%0d]: got %b want 0", k, bus.mem_read_enable); end
        end
    endtask

    task automatic test_timeout();
        bus.req_addr = {16'h0000, 16'h0044};
        bus.req_enable = 2'b01;
        tick();
        n_cmp++; if (bus.mem_read_enable !== 1'b1) begin n_bad++; $display("FAIL to_issue_re: got %b want 1", bus.mem_read_enable); end
        for (int c = 1; c <= 7; c++) begin
            tick();
            n_cmp++; if (bus.mem_read_enable !== 1'b1 || bus.timeout_error !== 1'b0) begin
                n_bad++; $display("FAIL to_wait[%0d]: got re=%b err=%b want re=1 err=0", c, bus.mem_read_enable, bus.timeout_error);
            end
        end
        tick();
        n_cmp++; if (bus.mem_read_enable !== 1'b0) begin n_bad++; $display("FAIL to_re_drop: got %b want 0", bus.mem_read_enable); end
        n_cmp++; if (bus.timeout_error !== 1'b1) begin n_bad++; $display("FAIL to_err_set: got %b want 1", bus.timeout_error); end
        n_cmp++; if (bus.req_ready !== 2'b00 || bus.busy !== 1'b0) begin n_bad++; $display("FAIL to_abort: got rdy=%b busy=%b want rdy=00 busy=0", bus.req_ready, bus.busy); end
        tick();
        n_cmp++; if (bus.mem_read_enable !== 1'b1 || bus.mem_addr !== 16'h0044) begin n_bad++; $display("FAIL to_reissue: got re=%b addr=%h want re=1 addr=0044", bus.mem_read_enable, bus.mem_addr); end
        bus.mem_data = 32'h5555AAAA; bus.mem_read_ready = 1'b1;
        tick();
        n_cmp++; if (bus.req_ready !== 2'b01 || bus.req_data !== 32'h5555AAAA) begin n_bad++; $display("FAIL to_served: got rdy=%b data=%h want rdy=01 data=5555aaaa", bus.req_ready, bus.req_data); end
        bus.mem_read_ready = 1'b0; bus.req_enable = 2'b00;
        tick();
        n_cmp++; if (bus.timeout_error !== 1'b1) begin n_bad++; $display("FAIL to_sticky: got %b want 1", bus.timeout_error); end
    endtask

    task automatic test_withdraw();
        bus.req_addr = {16'h0020, 16'h0010};
        bus.req_enable = 2'b11;
        tick();
        n_cmp++; if (bus.grant_index !== 3'd1 || bus.mem_addr !== 16'h0020) begin n_bad++; $display("FAIL wd_grant1: got g=%0d addr=%h want g=1 addr=0020", bus.grant_index, bus.mem_addr); end
        bus.req_enable = 2'b01;
        bus.mem_data = 32'h00000077; bus.mem_read_ready = 1'b1;
        tick();
        n_cmp++; if (bus.req_ready !== 2'b00) begin n_bad++; $display("FAIL wd_no_pulse: got %b want 00", bus.req_ready); end
        n_cmp++; if (bus.mem_read_enable !== 1'b0) begin n_bad++; $display("FAIL wd_read_done: got %b want 0", bus.mem_read_enable); end
        bus.mem_read_ready = 1'b0;
        tick(); tick();
        n_cmp++; if (bus.grant_index !== 3'd0 || bus.mem_addr !== 16'h0010) begin n_bad++; $display("FAIL wd_next0: got g=%0d addr=%h want g=0 addr=0010", bus.grant_index, bus.mem_addr); end
        bus.mem_data = 32'h00000088; bus.mem_read_ready = 1'b1;
        tick();
        n_cmp++; if (bus.req_ready !== 2'b01 || bus.req_data !== 32'h00000088) begin n_bad++; $display("FAIL wd_served0: got rdy=%b data=%h want rdy=01 data=00000088", bus.req_ready, bus.req_data); end
        bus.mem_read_ready = 1'b0; bus.req_enable = 2'b00;
        tick();
    endtask

    task automatic test_reset_mid();
        bus.req_addr = {16'h0030, 16'h0000};
        bus.req_enable = 2'b10;
        tick();
        n_cmp++; if (bus.mem_read_enable !== 1'b1) begin n_bad++; $display("FAIL rm_issue: got %b want 1", bus.mem_read_enable); end
        #2 reset = 1'b0;
        #1;
        n_cmp++; if (bus.mem_read_enable !== 1'b0 || bus.mem_addr !== 16'h0 || bus.busy !== 1'b0) begin
            n_bad++; $display("FAIL rm_async: got re=%b addr=%h busy=%b want 0/0000/0", bus.mem_read_enable, bus.mem_addr, bus.busy);
        end
        n_cmp++; if (bus.timeout_error !== 1'b0 || bus.req_data !== 32'h0 || bus.grant_index !== 3'd0) begin
            n_bad++; $display("FAIL rm_clear: got err=%b data=%h g=%0d want 0/0/0", bus.timeout_error, bus.req_data, bus.grant_index);
        end
        bus.mem_read_ready = 1'b1; bus.mem_data = 32'h12345678;
        tick();
        bus.mem_read_ready = 1'b0; bus.req_enable = 2'b00;
        reset = 1'b1;
        tick();
        n_cmp++; if (bus.req_ready !== 2'b00 || bus.busy !== 1'b0 || bus.mem_read_enable !== 1'b0) begin
            n_bad++; $display("FAIL rm_after: got rdy=%b busy=%b re=%b want 00/0/0", bus.req_ready, bus.busy, bus.mem_read_enable);
        end
        tick();
        n_cmp++; if (bus.req_ready !== 2'b00) begin n_bad++; $display("FAIL rm_no_pending: got %b want 00", bus.req_ready); end
    endtask

    task automatic test_ready_in_idle();
        bus.mem_data = 32'h00000099; bus.mem_read_ready = 1'b1;
        tick(); tick();
        n_cmp++; if (bus.busy !== 1'b0 || bus.mem_read_enable !== 1'b0) begin n_bad++; $display("FAIL idle_state: got busy=%b re=%b want 0/0", bus.busy, bus.mem_read_enable); end
        n_cmp++; if (bus.req_ready !== 2'b00) begin n_bad++; $display("FAIL idle_rdy: got %b want 00", bus.req_ready); end
        n_cmp++; if (bus.req_data !== 32'h0) begin n_bad++; $display("FAIL idle_data: got %h want 0", bus.req_data); end
        bus.mem_read_ready = 1'b0;
        tick();
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_single();
        test_alternate();
        test_timeout();
        test_withdraw();
        test_reset_mid();
        test_ready_in_idle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
